// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath. One instruction at a time is
//   walked through FETCH -> DECODE -> EXEC -> MEM -> WB. Each instruction skips
//   the phases it does not need. The FSM drives the PC, IR, register-file, ALU
//   and memory strobes and selects. Instruction and data accesses share one
//   memory port. That port uses a req/ready handshake, and any number of wait
//   states may occur.
//
// Parameters
//   CNT_W      width of the retired-instruction counter
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   command    5-bit command class from the op/func decoder:
//              0 nop, 1 add, 2 sub, 3 ori, 4 lw, 5 sw, 6 beq, 7 jal,
//              8 jr, 9 lui; values 10-31 behave as nop
//   zero       ALU equality flag, meaningful in EXEC
//   mem_ready  memory completes the current access this cycle
//   mem_req    memory access request (fetch or data)
//   mem_we     write qualifier for mem_req (sw only)
//   ir_we      load instruction register
//   pc_we      load PC
//   pc_sel     0 PC+4, 1 branch target, 2 jump target, 3 register rs
//   reg_we     register file write
//   reg_dst    0 rt, 1 rd, 2 $31
//   wd_sel     0 ALU result, 1 memory data, 2 PC (link)
//   alu_op     0 add, 1 sub, 2 or, 3 lui
//   alu_src    0 register rt, 1 immediate
//   ext_op     0 zero-extend, 1 sign-extend
//   state      0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
//   instr_cnt  retired instruction count (wraps silently)
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       command,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             ext_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_NOP = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2, C_ORI = 4'd3, C_LW  = 4'd4,
    C_SW  = 4'd5, C_BEQ = 4'd6, C_JAL = 4'd7, C_JR  = 4'd8, C_LUI = 4'd9
  } cmd_e;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d, cmd_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Strobes before reset gating
  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;

  // Unused command codes collapse to nop before they are latched
  always_comb begin
    cmd_in = C_NOP;
    if (command <= 5'd9) cmd_in = cmd_e'(command[3:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cmd_q   <= C_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    reg_we_c  = 1'b0;
    pc_sel    = 2'd0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    alu_op    = 3'd0;
    alu_src   = 1'b0;
    ext_op    = 1'b0;

    // The ALU is set up from the latched command in every post-decode phase.
    // This keeps its operands stable across memory wait states and writeback.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cmd_q)
        C_SUB, C_BEQ: alu_op = 3'd1;
        C_ORI: begin alu_op = 3'd2; alu_src = 1'b1; end
        C_LW, C_SW: begin alu_src = 1'b1; ext_op = 1'b1; end
        C_LUI: begin alu_op = 3'd3; alu_src = 1'b1; end
        default: ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      // Single-cycle instructions act on the live command, because cmd_q
      // only takes the new value at the end of this cycle.
      S_DECODE: begin
        cmd_d = cmd_in;
        case (cmd_in)
          C_NOP: state_d = S_FETCH;
          C_JAL: begin
            reg_we_c = 1'b1;
            reg_dst  = 2'd2;
            wd_sel   = 2'd2;
            pc_we_c  = 1'b1;
            pc_sel   = 2'd2;
            state_d  = S_FETCH;
          end
          C_JR: begin
            pc_we_c = 1'b1;
            pc_sel  = 2'd3;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cmd_q)
          C_BEQ: begin
            pc_we_c = zero;
            pc_sel  = 2'd1;
            state_d = S_FETCH;
          end
          C_LW, C_SW:                 state_d = S_MEM;
          C_ADD, C_SUB, C_ORI, C_LUI: state_d = S_WB;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cmd_q == C_SW);
        if (mem_ready) state_d = (cmd_q == C_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = (cmd_q == C_ADD || cmd_q == C_SUB) ? 2'd1 : 2'd0;
        wd_sel   = (cmd_q == C_LW) ? 2'd1 : 2'd0;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // An instruction retires whenever control returns to FETCH
    cnt_d = cnt_q;
    if (state_q != S_FETCH && state_d == S_FETCH) cnt_d = cnt_q + CNT_W'(1);
  end

  // While reset is asserted the strobes are gated off. FETCH would otherwise
  // raise mem_req, and a high mem_ready would fire ir_we/pc_we.
  assign mem_req   = mem_req_c & reset_n;
  assign mem_we    = mem_we_c  & reset_n;
  assign ir_we     = ir_we_c   & reset_n;
  assign pc_we     = pc_we_c   & reset_n;
  assign reg_we    = reg_we_c  & reset_n;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl (CNT_W=4 so counter wrap is reachable).
// Output vector layout: {mem_req,mem_we,ir_we,pc_we,pc_sel,reg_we,reg_dst,
//                        wd_sel,alu_op,alu_src,ext_op,state}
module tb_multi_cycle_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       command;
  logic             zero, mem_ready;
  logic             mem_req, mem_we, ir_we, pc_we, reg_we, alu_src, ext_op;
  logic [1:0]       pc_sel, reg_dst, wd_sel;
  logic [2:0]       alu_op, state;
  logic [CNT_W-1:0] instr_cnt;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .command(command), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst,
                    wd_sel, alu_op, alu_src, ext_op, state};

  int n_pass  = 0;
  int n_total = 0;
  int cnt_m   = 0;   // model of retired-instruction count

  typedef struct {
    logic [4:0]  cmd;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
    logic        last;   // final cycle of an instruction (retires)
  } vec_t;
  vec_t tbl[$];

  function automatic logic [18:0] mk(input int st, input int mrq, input int mwe,
                                     input int irw, input int pcw, input int pcs,
                                     input int rgw, input int rgd, input int wds,
                                     input int aop, input int asrc, input int ext);
    return {mrq[0], mwe[0], irw[0], pcw[0], pcs[1:0], rgw[0], rgd[1:0],
            wds[1:0], aop[2:0], asrc[0], ext[0], st[2:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One clock cycle: drive inputs just after posedge, check mid-cycle
  task automatic step(input logic [4:0] c, input logic z, input logic r,
                      input logic [18:0] e, input string nm);
    command   = c;
    zero      = z;
    mem_ready = r;
    @(negedge clk);
    chk({nm, "_outs"}, 32'(dut_vec), 32'(e));
    chk({nm, "_cnt"}, 32'(instr_cnt), 32'(cnt_m));
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [4:0] c, input logic z, input logic r,
                              input logic [18:0] e, input logic l);
    vec_t v;
    v.cmd = c; v.z = z; v.rdy = r; v.exp = e; v.last = l;
    tbl.push_back(v);
  endfunction

  // Reference model: per-instruction phase plan derived from the class rules
  task automatic run_instr(input logic [4:0] raw, input int wf, input int wm);
    int c, aop, asrc, ext, zz;
    c = (raw > 5'd9) ? 0 : int'(raw);
    aop = 0; asrc = 0; ext = 0;
    case (c)
      2, 6: aop = 1;
      3: begin aop = 2; asrc = 1; end
      4, 5: begin asrc = 1; ext = 1; end
      9: begin aop = 3; asrc = 1; end
      default: ;
    endcase
    for (int i = 0; i < wf; i++)
      step(5'($urandom), 1'($urandom), 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
    step(5'($urandom), 1'($urandom), 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0), "fetch");
    if (c == 7)      step(raw, 1'($urandom), 1'($urandom), mk(1,0,0,0,1,2,1,2,2,0,0,0), "dec_jal");
    else if (c == 8) step(raw, 1'($urandom), 1'($urandom), mk(1,0,0,0,1,3,0,0,0,0,0,0), "dec_jr");
    else             step(raw, 1'($urandom), 1'($urandom), mk(1,0,0,0,0,0,0,0,0,0,0,0), "decode");
    if (c != 0 && c != 7 && c != 8) begin
      zz = int'($urandom_range(0, 1));
      step(5'($urandom), zz[0], 1'($urandom),
           mk(2,0,0,0,(c == 6) ? zz : 0,(c == 6) ? 1 : 0,0,0,0,aop,asrc,ext), "exec");
      if (c == 4 || c == 5) begin
        for (int i = 0; i < wm; i++)
          step(5'($urandom), 1'($urandom), 1'b0,
               mk(3,1,(c == 5) ? 1 : 0,0,0,0,0,0,0,aop,asrc,ext), "mem_wait");
        step(5'($urandom), 1'($urandom), 1'b1,
             mk(3,1,(c == 5) ? 1 : 0,0,0,0,0,0,0,aop,asrc,ext), "mem");
      end
      if (c != 5 && c != 6)
        step(5'($urandom), 1'($urandom), 1'($urandom),
             mk(4,0,0,0,0,0,1,(c == 1 || c == 2) ? 1 : 0,(c == 4) ? 2'd1 : 0,aop,asrc,ext), "wb");
    end
    cnt_m = (cnt_m + 1) % (1 << CNT_W);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outs", 32'(dut_vec), 32'd0);
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cnt_m = 0;
  endtask

  initial begin
    command = '0; zero = 1'b0; mem_ready = 1'b1; reset_n = 1'b0;
    #12;
    do_reset();

    // Directed sequences
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // lw, no waits
    add(4,0,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,0,0, mk(2,0,0,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,1, mk(3,1,0,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,0, mk(4,0,0,0,0,0,1,0,1,0,1,1), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // beq taken
    add(6,0,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,1,0, mk(2,0,0,0,1,1,0,0,0,1,0,0), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // beq not taken
    add(6,1,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,0,1, mk(2,0,0,0,0,1,0,0,0,1,0,0), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // jal
    add(7,0,1, mk(1,0,0,0,1,2,1,2,2,0,0,0), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // command 17 = nop
    add(17,0,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // jr
    add(8,0,0, mk(1,0,0,0,1,3,0,0,0,0,0,0), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // sw, 3 wait states
    add(5,0,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,0,0, mk(2,0,0,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,0, mk(3,1,1,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,0, mk(3,1,1,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,0, mk(3,1,1,0,0,0,0,0,0,0,1,1), 0);
    add(0,0,1, mk(3,1,1,0,0,0,0,0,0,0,1,1), 1);
    add(0,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0), 0);   // add
    add(1,0,0, mk(1,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,0,0, mk(2,0,0,0,0,0,0,0,0,0,0,0), 0);
    add(0,0,0, mk(4,0,0,0,0,0,1,1,0,0,0,0), 1);
    foreach (tbl[i]) begin
      step(tbl[i].cmd, tbl[i].z, tbl[i].rdy, tbl[i].exp, "tbl");
      if (tbl[i].last) cnt_m = (cnt_m + 1) % (1 << CNT_W);
    end
    step(5'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0), "after_tbl");

    // Reset in the MEM wait of a lw
    step(5'd0, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0), "rst_f");
    step(5'd4, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,0), "rst_d");
    step(5'd0, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,0,0,0,1,1), "rst_e");
    command = 5'd0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_mem_req_before", 32'(mem_req), 32'd1);
    chk("rst_cnt_before", 32'(instr_cnt), 32'(cnt_m));
    do_reset();
    run_instr(5'd4, 0, 0);

    // Counter wrap with 16 nops
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(5'd0, 0, 0);
    chk("wrap15", 32'(instr_cnt), 32'd15);
    run_instr(5'd0, 0, 0);
    chk("wrap0", 32'(instr_cnt), 32'd0);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++)
      run_instr(5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
